cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter IT_DEPTH, default 4, maximum number of predicated slots in one IT block (range 1..8).
REQ-002 Parameter NWE, default 3, number of write-enable strobes gated (e.g. PCS, RegW, MemW).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Cond  input  4  condition field of the current instruction.
REQ-006 ALUFlags  input  4  NZCV result flags from the ALU, bit 3 = N.
REQ-007 FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
REQ-008 WeIn  input  NWE  raw write-enables from the decoder.
REQ-009 Advance  input  1  current instruction retires this cycle (0 = stall).
REQ-010 ItStart  input  1  current instruction opens an IT block.
REQ-011 ItCond  input  4  base condition of the IT block.
REQ-012 ItMask  input  IT_DEPTH  bit i=1: slot i uses ItCond; bit i=0: slot i uses the inverse condition.
REQ-013 ItLen  input  $clog2(IT_DEPTH+1)  number of slots in the block.
REQ-014 WeOut  output  NWE  gated write-enables.
REQ-015 CondEx  output  1  effective condition passes.
REQ-016 Flags  output  4  registered NZCV.
REQ-017 ItActive  output  1  an IT block is in progress.
REQ-018 ItRemain  output  $clog2(IT_DEPTH+1)  slots left in the block.

Function
REQ-019 The effective condition SHALL be Cond when ItActive=0, else the slot condition for the current slot index.
REQ-020 The slot condition SHALL be ItCond when ItMask[slot]=1, else ItCond with bit 0 inverted; when ItCond=1110, every slot SHALL be 1110.
REQ-021 CondEx SHALL be evaluated combinationally from the registered Flags: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 0.
REQ-022 WeOut SHALL equal WeIn AND-ed with (CondEx & Advance) on every bit.
REQ-023 On a clock edge with Advance=1, CondEx=1 and FlagW[1]=1, Flags[3:2] SHALL load ALUFlags[3:2]; with FlagW[0]=1, Flags[1:0] SHALL load ALUFlags[1:0]; otherwise Flags SHALL hold.
REQ-024 The IT FSM SHALL have two states, IDLE and ACTIVE.
REQ-025 IDLE->ACTIVE SHALL occur on an edge with ItStart=1, Advance=1 and 1<=ItLen<=IT_DEPTH; it SHALL latch ItCond and ItMask, set ItRemain=ItLen and set the slot index to 0.
REQ-026 In IDLE, ItStart with ItLen=0 or ItLen>IT_DEPTH SHALL be ignored.
REQ-027 In ACTIVE, each edge with Advance=1 SHALL decrement ItRemain and increment the slot index, whether or not CondEx passes; when ItRemain goes from 1 to 0, the FSM SHALL return to IDLE.
REQ-028 Advance=0 SHALL hold the FSM state, slot index, ItRemain and Flags.
REQ-029 ItStart in ACTIVE SHALL be ignored (no nesting), and that instruction SHALL be evaluated under its slot condition.
REQ-030 Flags written by one slot SHALL be visible to the condition evaluation of the next slot.
REQ-031 The IT-opening instruction itself SHALL be evaluated under Cond as a normal instruction.
REQ-032 ItActive SHALL equal (state==ACTIVE).

Reset
REQ-033 Reset SHALL set Flags=0000, state=IDLE, ItRemain=0, slot index=0 and latched mask/condition=0, overriding Advance and ItStart in the same cycle.
REQ-034 Reset asserted mid-block SHALL abandon the block; the next instruction SHALL be evaluated under Cond.

Verification
REQ-035 After reset, Cond=0000, WeIn=111, Advance=1 -> CondEx=0, WeOut=000; then Cond=0001 -> CondEx=1, WeOut=111.
REQ-036 Cond=1110, FlagW=10, ALUFlags=1111 -> next Flags=1100; then FlagW=01, ALUFlags=0011 -> Flags=1111.
REQ-037 Flags=0000, Cond=0000, FlagW=11, ALUFlags=0100 -> CondEx=0, Flags stay 0000; the same stimulus with Advance=0 and Cond=1110 -> Flags stay 0000.
REQ-038 Flags Z=1, ItStart, ItCond=0000, ItMask=0101, ItLen=3 -> slots 0/1/2 give CondEx=1/0/1, with ItRemain 3->2->1->0 and ItActive falling after slot 2; one Advance=0 cycle inserted at slot 1 holds ItRemain=2.
REQ-039 Reset asserted after slot 0 of a 4-slot block -> ItActive=0, ItRemain=0, Flags=0000; the next Cond=1110 instruction -> CondEx=1.
REQ-040 Cond=1111 with any Flags -> CondEx=0, WeOut=0; ItStart with ItLen=0 -> ItActive stays 0.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, condition check,
// write-enable gating and a Thumb-style IT block sequencer.
module cond_unit #(
  parameter int IT_DEPTH = 4,
  parameter int NWE      = 3,
  localparam int LW      = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [1:0]          FlagW,
  input  logic [NWE-1:0]      WeIn,
  input  logic                Advance,
  input  logic                ItStart,
  input  logic [3:0]          ItCond,
  input  logic [IT_DEPTH-1:0] ItMask,
  input  logic [LW-1:0]       ItLen,
  output logic [NWE-1:0]      WeOut,
  output logic                CondEx,
  output logic [3:0]          Flags,
  output logic                ItActive,
  output logic [LW-1:0]       ItRemain
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [LW-1:0] DEPTH_L = LW'(IT_DEPTH);
  localparam logic [3:0]    AL      = 4'b1110;

  state_e              state_q;
  logic [3:0]          flags_q;
  logic [3:0]          cond_q;
  logic [IT_DEPTH-1:0] mask_q;
  logic [LW-1:0]       remain_q;
  logic [LW-1:0]       slot_q;

  logic       slot_bit;
  logic [3:0] eff_cond;
  logic       n_f, z_f, c_f, v_f;
  logic       len_ok;

  always_comb begin
    slot_bit = 1'b0;
    for (int i = 0; i < IT_DEPTH; i++) begin
      if (slot_q == LW'(i)) slot_bit = mask_q[i];
    end
  end

  // A clear mask bit selects the inverse condition, except for AL,
  // which has no meaningful inverse.
  always_comb begin
    eff_cond = Cond;
    if (state_q == ACTIVE) begin
      if (cond_q == AL || slot_bit)
        eff_cond = cond_q;
      else
        eff_cond = {cond_q[3:1], ~cond_q[0]};
    end
  end

  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign c_f = flags_q[1];
  assign v_f = flags_q[0];

  always_comb begin
    CondEx = 1'b0;
    case (eff_cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign len_ok = (ItLen != '0) && (ItLen <= DEPTH_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      flags_q  <= '0;
      cond_q   <= '0;
      mask_q   <= '0;
      remain_q <= '0;
      slot_q   <= '0;
    end else if (Advance) begin
      if (CondEx) begin
        if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
      unique case (state_q)
        IDLE: begin
          if (ItStart && len_ok) begin
            state_q  <= ACTIVE;
            cond_q   <= ItCond;
            mask_q   <= ItMask;
            remain_q <= ItLen;
            slot_q   <= '0;
          end
        end
        ACTIVE: begin
          remain_q <= remain_q - LW'(1);
          slot_q   <= slot_q + LW'(1);
          if (remain_q == LW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WeOut    = WeIn & {NWE{CondEx & Advance}};
  assign Flags    = flags_q;
  assign ItActive = (state_q == ACTIVE);
  assign ItRemain = remain_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios then random traffic,
// all compared against a queue-based behavioural model.
module tb_cond_unit;

  localparam int D  = 4;
  localparam int NW = 3;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    Cond, ALUFlags, ItCond;
  logic [1:0]    FlagW;
  logic [NW-1:0] WeIn, WeOut;
  logic          Advance, ItStart, CondEx, ItActive;
  logic [D-1:0]  ItMask;
  logic [LW-1:0] ItLen, ItRemain;
  logic [3:0]    Flags;

  int checks   = 0;
  int failures = 0;

  logic [3:0] mf;
  logic [3:0] slots[$];

  always #5 clk = ~clk;

  cond_unit #(.IT_DEPTH(D), .NWE(NW)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .WeIn(WeIn), .Advance(Advance),
    .ItStart(ItStart), .ItCond(ItCond), .ItMask(ItMask),
    .ItLen(ItLen), .WeOut(WeOut), .CondEx(CondEx), .Flags(Flags),
    .ItActive(ItActive), .ItRemain(ItRemain)
  );

  function automatic bit pass(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;
      1: return !z;
      2: return cy;
      3: return !cy;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cy && !z;
      9: return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step(input bit rst, input bit adv, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw,
                      input logic [NW-1:0] we, input bit st,
                      input logic [3:0] ic, input logic [D-1:0] im,
                      input logic [LW-1:0] il);
    logic [3:0] ec;
    bit p;
    reset = rst; Advance = adv; Cond = c; ALUFlags = af;
    FlagW = fw; WeIn = we; ItStart = st; ItCond = ic;
    ItMask = im; ItLen = il;
    #1;
    ec = (slots.size() > 0) ? slots[0] : c;
    p = pass(ec, mf);
    chk("CondEx", 32'(CondEx), 32'(p));
    chk("WeOut", 32'(WeOut), (adv && p) ? 32'(we) : 32'd0);
    @(posedge clk);
    if (rst) begin
      mf = 4'b0000;
      slots.delete();
    end else if (adv) begin
      if (p && fw[1]) mf[3:2] = af[3:2];
      if (p && fw[0]) mf[1:0] = af[1:0];
      if (slots.size() > 0) begin
        void'(slots.pop_front());
      end else if (st && il >= 1 && il <= D) begin
        for (int i = 0; i < int'(il); i++)
          slots.push_back((ic == 4'hE) ? 4'hE : (im[i] ? ic : ic ^ 4'h1));
      end
    end
    #1;
    chk("Flags", 32'(Flags), 32'(mf));
    chk("ItActive", 32'(ItActive), 32'(slots.size() > 0));
    chk("ItRemain", 32'(ItRemain), 32'(slots.size()));
  endtask

  initial begin
    reset = 1'b1; Advance = 1'b1; Cond = 4'h0; ALUFlags = 4'h0;
    FlagW = 2'b00; WeIn = '0; ItStart = 1'b0; ItCond = 4'h0;
    ItMask = '0; ItLen = '0;
    mf = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 32'(Flags), 32'h0);
    chk("rst_active", 32'(ItActive), 32'h0);
    chk("rst_remain", 32'(ItRemain), 32'h0);

    // EQ fails, NE passes on cleared flags
    step(0, 1, 4'h0, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    chk("eq_zero", 32'(CondEx), 32'h0);
    step(0, 1, 4'h1, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    // partial flag writes
    step(0, 1, 4'hE, 4'hF, 2'b10, 3'b000, 0, 4'h0, 4'h0, 3'd0);
    chk("fw_nz", 32'(Flags), 32'hC);
    step(0, 1, 4'hE, 4'h3, 2'b01, 3'b000, 0, 4'h0, 4'h0, 3'd0);
    chk("fw_cv", 32'(Flags), 32'hF);
    // failing condition and stall both block flag writes
    step(1, 1, 4'hE, 4'h0, 2'b00, 3'b000, 0, 4'h0, 4'h0, 3'd0);
    step(0, 1, 4'h0, 4'h4, 2'b11, 3'b101, 0, 4'h0, 4'h0, 3'd0);
    step(0, 0, 4'hE, 4'h4, 2'b11, 3'b101, 0, 4'h0, 4'h0, 3'd0);
    chk("stall_flags", 32'(Flags), 32'h0);
    // IT EQ block, mask 0101, len 3, stall at slot 1
    step(0, 1, 4'hE, 4'h4, 2'b10, 3'b000, 0, 4'h0, 4'h0, 3'd0);
    step(0, 1, 4'hE, 4'h0, 2'b00, 3'b111, 1, 4'h0, 4'h5, 3'd3);
    chk("it_open", 32'(ItRemain), 32'h3);
    step(0, 1, 4'hF, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    step(0, 0, 4'hF, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    chk("it_stall", 32'(ItRemain), 32'h2);
    step(0, 1, 4'hF, 4'h0, 2'b00, 3'b111, 1, 4'h1, 4'hF, 3'd2);
    step(0, 1, 4'hF, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    chk("it_done", 32'(ItActive), 32'h0);
    // reset mid-block
    step(0, 1, 4'hE, 4'h0, 2'b00, 3'b111, 1, 4'hE, 4'h0, 3'd4);
    step(0, 1, 4'hE, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    step(1, 1, 4'hE, 4'h0, 2'b00, 3'b111, 1, 4'h0, 4'hF, 3'd2);
    chk("rst_mid", 32'(ItActive), 32'h0);
    step(0, 1, 4'hE, 4'h0, 2'b00, 3'b111, 0, 4'h0, 4'h0, 3'd0);
    // NV never passes; zero-length IT ignored
    step(0, 1, 4'hF, 4'h0, 2'b00, 3'b111, 1, 4'h0, 4'h0, 3'd0);
    chk("len0", 32'(ItActive), 32'h0);
    step(0, 1, 4'hE, 4'h0, 2'b00, 3'b111, 1, 4'h0, 4'h0, 3'd5);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           4'($urandom), 4'($urandom), 2'($urandom), NW'($urandom),
           ($urandom_range(0, 5) == 0),
           4'($urandom), D'($urandom), LW'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
